// File: rtl/inst_sram_responder.sv
// inst_sram_responder: in-order SRAM-style responder over a synchronous RAM,
// tracking up to OUTSTANDING requests, each answered no sooner than LATENCY cycles.
module inst_sram_responder #(
    parameter int OUTSTANDING = 2,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic [31:0] sram_addr_ok_addr,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata,
    input  logic        stall,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    logic [1:0]  head, tail, cap_idx;
    logic [2:0]  count;
    logic        cap_pend, accept, retire, cap_head;
    logic [3:0]  e_wr, e_cap;
    logic [3:0]  e_cd [4];
    logic [31:0] e_data [4];
    logic [31:0] head_data;
    logic        unused_size;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign unused_size       = ^sram_size;
    assign accept            = ~reset & sram_en & ~stall & (count < 3'(OUTSTANDING));
    // The newest entry gets its RAM word one cycle after acceptance; if that entry is
    // already the head with no countdown left, forward the RAM output directly.
    assign cap_head          = cap_pend & (cap_idx == head);
    assign head_data         = cap_head ? (e_wr[head] ? 32'h0 : ram_rdata) : e_data[head];
    assign retire            = ~reset & (count != 3'd0) & (e_cd[head] == 4'd0) & (e_cap[head] | cap_head);
    assign sram_addr_ok      = accept;
    assign sram_addr_ok_addr = accept ? sram_addr : 32'h0;
    assign sram_data_ok      = retire;
    assign sram_rdata        = retire ? head_data : 32'h0;
    assign ram_en            = accept;
    assign ram_we            = (accept & sram_wr) ? sram_wen : 4'h0;
    assign ram_addr          = sram_addr[31:2];
    assign ram_wdata         = sram_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            count    <= 3'd0;
            cap_pend <= 1'b0;
            cap_idx  <= 2'd0;
            e_cap    <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (e_cd[i] != 4'd0) e_cd[i] <= e_cd[i] - 4'd1;
            if (cap_pend) begin
                e_cap[cap_idx]  <= 1'b1;
                e_data[cap_idx] <= e_wr[cap_idx] ? 32'h0 : ram_rdata;
            end
            if (accept) begin
                e_wr[tail]  <= sram_wr;
                e_cd[tail]  <= 4'(LATENCY - 1);
                e_cap[tail] <= 1'b0;
                tail        <= nxt(tail);
            end
            if (retire) head <= nxt(head);
            count    <= count + {2'b0, accept} - {2'b0, retire};
            cap_pend <= accept;
            cap_idx  <= tail;
        end
    end
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: two responder instances (LATENCY 2/OUTSTANDING 2 and
// LATENCY 1/OUTSTANDING 3) against a queue-style timing and memory model.
module tb_inst_sram_responder;
    localparam int LAT  [2] = '{2, 1};
    localparam int OUTS [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        reset, sram_en, sram_wr, stall;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic        aok [2];
    logic [31:0] aok_addr [2];
    logic        dok [2];
    logic [31:0] rdata [2];
    logic        ram_en [2];
    logic [3:0]  ram_we [2];
    logic [29:0] ram_addr [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic [31:0] mem [2][128];

    logic [31:0] ref_mem [2][128];
    int          m_due [2][4];
    logic [31:0] m_data [2][4];
    int          m_head [2], m_cnt [2], last_due [2];
    int          now, total, bad;

    always #5 clk = ~clk;

    inst_sram_responder #(.OUTSTANDING(2), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .sram_en(sram_en), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(aok[0]), .sram_addr_ok_addr(aok_addr[0]), .sram_data_ok(dok[0]),
        .sram_rdata(rdata[0]), .stall(stall), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    inst_sram_responder #(.OUTSTANDING(3), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .sram_en(sram_en), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(aok[1]), .sram_addr_ok_addr(aok_addr[1]), .sram_data_ok(dok[1]),
        .sram_rdata(rdata[1]), .stall(stall), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // Synchronous backing RAMs, read-before-write, one per instance.
    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (ram_en[i]) begin
                ram_rdata[i] <= mem[i][ram_addr[i][6:0]];
                for (int b = 0; b < 4; b++)
                    if (ram_we[i][b]) mem[i][ram_addr[i][6:0]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
            end

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, inst, obs, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic wr, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic st, input logic rs);
        logic        exp_ok, exp_dok;
        logic [31:0] exp_rd, w;
        int          idx;
        sram_en = en; sram_wr = wr; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
        stall = st; reset = rs; sram_size = 2'($urandom_range(0, 3));
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_ok  = !rs && en && !st && (m_cnt[i] < OUTS[i]);
            exp_dok = !rs && (m_cnt[i] > 0) && (m_due[i][m_head[i]] == now);
            exp_rd  = exp_dok ? m_data[i][m_head[i]] : 32'h0;
            chk("addr_ok", i, 32'(aok[i]), 32'(exp_ok));
            chk("addr_ok_addr", i, aok_addr[i], exp_ok ? addr : 32'h0);
            chk("ram_en", i, 32'(ram_en[i]), 32'(exp_ok));
            chk("ram_we", i, 32'(ram_we[i]), (exp_ok && wr) ? 32'(wen) : 32'h0);
            if (exp_ok) begin
                chk("ram_addr", i, 32'(ram_addr[i]), {2'b0, addr[31:2]});
                chk("ram_wdata", i, ram_wdata[i], wdata);
            end
            chk("data_ok", i, 32'(dok[i]), 32'(exp_dok));
            chk("rdata", i, rdata[i], exp_rd);
            if (rs) begin
                m_cnt[i] = 0; m_head[i] = 0; last_due[i] = 0;
            end else begin
                if (exp_ok) begin
                    idx = (m_head[i] + m_cnt[i]) % OUTS[i];
                    m_due[i][idx] = (now + LAT[i] > last_due[i] + 1) ? now + LAT[i] : last_due[i] + 1;
                    last_due[i] = m_due[i][idx];
                    w = ref_mem[i][addr[8:2]];
                    m_data[i][idx] = wr ? 32'h0 : w;
                    if (wr)
                        for (int b = 0; b < 4; b++)
                            if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
                    ref_mem[i][addr[8:2]] = w;
                    m_cnt[i]++;
                end
                if (exp_dok) begin
                    m_head[i] = (m_head[i] + 1) % OUTS[i];
                    m_cnt[i]--;
                end
            end
        end
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b0, 4'hF, a, 32'hA5A5_5A5A, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        total = 0; bad = 0; now = 0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_head[i] = 0; last_due[i] = 0;
            for (int j = 0; j < 128; j++) begin
                a = $urandom;
                a = (j == 0) ? 32'h3C08_BFC0 : (j == 64) ? 32'h1122_3344 : a;
                mem[i][j] = a;
                ref_mem[i][j] = a;
            end
        end
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        rd(32'hBFC0_0000);
        idle(3);
        rd(32'h0000_0010); rd(32'h0000_0014); rd(32'h0000_0018); rd(32'h0000_0018);
        idle(4);
        for (int k = 0; k < 6; k++) rd(32'h20 + 32'(k) * 4);
        idle(4);
        cyc(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rd(32'h0000_0100);
        idle(4);
        rd(32'h0000_0040);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0, 1'b1, 1'b0);
        rd(32'h0000_0044);
        idle(3);
        rd(32'h0000_0048); rd(32'h0000_004C);
        cyc(1'b1, 1'b0, 4'h0, 32'h0000_0050, 32'h0, 1'b0, 1'b1);
        rd(32'h0000_0050);
        idle(5);
        for (int k = 0; k < 400; k++) begin
            a = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 4'($urandom), a, $urandom,
                $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
        end
        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
